unibus_dmamaster: RTL and testbench

ARM-driven UNIBUS NPR master. Lets the ARM perform single-word DATI/DATO/DATOB cycles on the UNIBUS, such as console examine/deposit or reading the switch register at 777570. It sits beside the switches-and-lights slave on the same bus interface and uses the same 4-register ARM window. It requests the bus with NPR, takes mastership with SACK/BBSY, runs one MSYN/SSYN handshake, then releases the bus.

---
 rtl/unibus_dmamaster_pkg.sv | 21 ++
 rtl/unibus_dmamaster.sv | 214 +++++++++++++++++++++
 tb/tb_unibus_dmamaster.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/unibus_dmamaster_pkg.sv
// rtl/unibus_dmamaster_pkg.sv - shared types and constants for the UNIBUS NPR master
package unibus_dmamaster_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK,
    ST_DRIVE,
    ST_MSYN,
    ST_REL
  } state_t;

  localparam logic [31:0] IDENT_WORD = 32'h444D1001;
  localparam logic [31:0] FILL_WORD  = 32'hDEADBEEF;

  localparam logic [1:0] REG_IDENT = 2'd0;
  localparam logic [1:0] REG_CTRL  = 2'd1;
  localparam logic [1:0] REG_DATA  = 2'd2;
  localparam logic [1:0] REG_FILL  = 2'd3;

endpackage

// File: rtl/unibus_dmamaster.sv
// rtl/unibus_dmamaster.sv - ARM-driven single-word UNIBUS NPR master (DATI/DATO/DATOB)
module unibus_dmamaster
  import unibus_dmamaster_pkg::*;
#(
  parameter int DESKEW  = 15,
  parameter int GRANTTO = 1000,
  parameter int SSYNTO  = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        npg_in_l,
  input  logic        bbsy_in_h,
  input  logic        ssyn_in_h,
  input  logic [15:0] d_in_h,
  input  logic        init_in_h,
  output logic        npr_out_h,
  output logic        sack_out_h,
  output logic        bbsy_out_h,
  output logic        msyn_out_h,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h
);

  localparam int CMAX01 = (DESKEW > GRANTTO) ? DESKEW : GRANTTO;
  localparam int CMAX   = (CMAX01 > SSYNTO) ? CMAX01 : SSYNTO;
  localparam int CW     = $clog2(CMAX + 1);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [17:0] addr_q, addr_d;
  logic [1:0]  c_q, c_d;
  logic [15:0] data_q, data_d;
  logic        busy_q, busy_d;
  logic        gerr_q, gerr_d;
  logic        serr_q, serr_d;
  logic        aborted_q, aborted_d;
  logic        npr_q, npr_d;
  logic        sack_q, sack_d;
  logic        bbsy_q, bbsy_d;
  logic        msyn_q, msyn_d;
  logic [17:0] aout_q, aout_d;
  logic [1:0]  cout_q, cout_d;
  logic [15:0] dout_q, dout_d;

  logic start;
  logic drive;
  logic abort_now;
  logic unused_wdata;

  assign unused_wdata = ^armwdata[30:20];
  assign start = armwrite && (armwaddr == REG_CTRL) && armwdata[31] && !busy_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    c_d       = c_q;
    data_d    = data_q;
    busy_d    = busy_q;
    gerr_d    = gerr_q;
    serr_d    = serr_q;
    aborted_d = aborted_q;

    if (armwrite && (armwaddr == REG_DATA) && !busy_q)
      data_d = armwdata[15:0];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d    = armwdata[17:0];
          c_d       = armwdata[19:18];
          gerr_d    = 1'b0;
          serr_d    = 1'b0;
          aborted_d = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = CW'(GRANTTO - 1);
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!npg_in_l) begin
          state_d = ST_ACK;
        end else if (cnt_q == '0) begin
          gerr_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ACK: begin
        if (npg_in_l && !bbsy_in_h && !ssyn_in_h) begin
          cnt_d   = CW'(DESKEW - 1);
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(SSYNTO - 1);
          state_d = ST_MSYN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_MSYN: begin
        if (ssyn_in_h) begin
          if (!c_q[1]) data_d = d_in_h;
          cnt_d   = CW'(SSYNTO - 1);
          state_d = ST_REL;
        end else if (cnt_q == '0) begin
          serr_d  = 1'b1;
          cnt_d   = CW'(SSYNTO - 1);
          state_d = ST_REL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_REL: begin
        // A slave that never drops SSYN is reported the same way as one that never raised it.
        if (!ssyn_in_h || (cnt_q == '0)) begin
          if (ssyn_in_h) serr_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_now) begin
      data_d    = data_q;
      gerr_d    = gerr_q;
      serr_d    = serr_q;
      aborted_d = 1'b1;
      busy_d    = 1'b0;
      state_d   = ST_IDLE;
    end

    // Bus outputs are registered from the next state so they line up with state_q.
    drive  = (state_d == ST_DRIVE) || (state_d == ST_MSYN) || (state_d == ST_REL);
    npr_d  = (state_d == ST_REQ);
    sack_d = (state_d == ST_ACK);
    bbsy_d = drive;
    msyn_d = (state_d == ST_MSYN);
    aout_d = drive ? addr_d : 18'd0;
    cout_d = drive ? c_d : 2'd0;
    dout_d = (drive && c_d[1]) ? data_d : 16'd0;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      c_q       <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      gerr_q    <= 1'b0;
      serr_q    <= 1'b0;
      aborted_q <= 1'b0;
      npr_q     <= 1'b0;
      sack_q    <= 1'b0;
      bbsy_q    <= 1'b0;
      msyn_q    <= 1'b0;
      aout_q    <= '0;
      cout_q    <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      c_q       <= c_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      gerr_q    <= gerr_d;
      serr_q    <= serr_d;
      aborted_q <= aborted_d;
      npr_q     <= npr_d;
      sack_q    <= sack_d;
      bbsy_q    <= bbsy_d;
      msyn_q    <= msyn_d;
      aout_q    <= aout_d;
      cout_q    <= cout_d;
      dout_q    <= dout_d;
    end
  end

  // INIT must clear the bus in the cycle it is seen, ahead of the registers.
  assign abort_now  = init_in_h && (state_q != ST_IDLE);
  assign npr_out_h  = npr_q  && !abort_now;
  assign sack_out_h = sack_q && !abort_now;
  assign bbsy_out_h = bbsy_q && !abort_now;
  assign msyn_out_h = msyn_q && !abort_now;
  assign a_out_h    = abort_now ? 18'd0 : aout_q;
  assign c_out_h    = abort_now ? 2'd0  : cout_q;
  assign d_out_h    = abort_now ? 16'd0 : dout_q;

  always_comb begin
    case (armraddr)
      REG_IDENT: armrdata = IDENT_WORD;
      REG_CTRL:  armrdata = {busy_q, gerr_q, serr_q, aborted_q, 8'b0, c_q, addr_q};
      REG_DATA:  armrdata = {16'b0, data_q};
      default:   armrdata = FILL_WORD;
    endcase
  end

endmodule

// File: tb/tb_unibus_dmamaster.sv
// tb/tb_unibus_dmamaster.sv - bench for unibus_dmamaster with a switch/lights slave at 777570
module tb_unibus_dmamaster;

  logic        CLOCK, RESET, armwrite;
  logic [1:0]  armraddr, armwaddr;
  logic [31:0] armwdata, armrdata;
  logic        npg_in_l, bbsy_in_h, ssyn_in_h, init_in_h;
  logic [15:0] d_in_h;
  logic        npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h;
  logic [17:0] a_out_h;
  logic [1:0]  c_out_h;
  logic [15:0] d_out_h;

  logic        grant_en, sel;
  logic [15:0] sw, lights;
  int          n_chk, n_fail, cyc;
  int          first_npr, first_sack, first_bbsy, first_msyn, msyn_cnt;
  logic [1:0]  c_msyn;

  unibus_dmamaster dut (
    .CLOCK(CLOCK), .RESET(RESET), .armwrite(armwrite), .armraddr(armraddr),
    .armwaddr(armwaddr), .armwdata(armwdata), .armrdata(armrdata),
    .npg_in_l(npg_in_l), .bbsy_in_h(bbsy_in_h), .ssyn_in_h(ssyn_in_h),
    .d_in_h(d_in_h), .init_in_h(init_in_h), .npr_out_h(npr_out_h),
    .sack_out_h(sack_out_h), .bbsy_out_h(bbsy_out_h), .msyn_out_h(msyn_out_h),
    .a_out_h(a_out_h), .c_out_h(c_out_h), .d_out_h(d_out_h)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Arbiter grants immediately while enabled; slave answers word 777570/777571 immediately.
  assign npg_in_l  = !(grant_en && npr_out_h);
  assign bbsy_in_h = 1'b0;
  assign sel       = (a_out_h[17:1] == 17'h1FFBC);
  assign ssyn_in_h = msyn_out_h && sel;
  assign d_in_h    = (msyn_out_h && sel && !c_out_h[1]) ? sw : 16'h0000;

  always @(posedge CLOCK) begin
    if (RESET) lights <= 16'h0000;
    else if (msyn_out_h && sel && c_out_h[1]) begin
      if (c_out_h[0]) begin
        if (a_out_h[0]) lights[15:8] <= d_out_h[15:8];
        else            lights[7:0]  <= d_out_h[7:0];
      end else lights <= d_out_h;
    end
  end

  typedef struct {
    logic [31:0] r2w;
    logic [31:0] r1w;
    logic [15:0] sw;
    logic [31:0] exp_r1;
    logic [31:0] exp_r2;
    logic [15:0] exp_lights;
    logic [1:0]  exp_c;
  } vec_t;

  vec_t tv[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge CLOCK);
    cyc++;
    if (npr_out_h  && first_npr  < 0) first_npr  = cyc;
    if (sack_out_h && first_sack < 0) first_sack = cyc;
    if (bbsy_out_h && first_bbsy < 0) first_bbsy = cyc;
    if (msyn_out_h) begin
      if (first_msyn < 0) first_msyn = cyc;
      msyn_cnt++;
      c_msyn = c_out_h;
    end
  endtask

  task automatic clr_mon();
    first_npr = -1; first_sack = -1; first_bbsy = -1; first_msyn = -1;
    msyn_cnt = 0; c_msyn = 2'd0;
  endtask

  task automatic arm_wr(input logic [1:0] a, input logic [31:0] d);
    armwaddr = a; armwdata = d; armwrite = 1'b1;
    step();
    armwrite = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    armraddr = a;
    #1;
    v = armrdata;
    armraddr = 2'd1;
  endtask

  task automatic wait_idle(input int lim, output logic ok);
    logic [31:0] v;
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      rd(2'd1, v);
      if (!v[31]) ok = 1'b1;
      else step();
    end
  endtask

  function automatic logic bus_active();
    return npr_out_h | sack_out_h | bbsy_out_h | msyn_out_h | (|a_out_h) | (|c_out_h) | (|d_out_h);
  endfunction

  initial begin
    logic [31:0] v;
    logic ok;
    n_chk = 0; n_fail = 0; cyc = 0;
    RESET = 1'b1; armwrite = 1'b0; armraddr = 2'd1; armwaddr = 2'd0; armwdata = 32'h0;
    init_in_h = 1'b0; grant_en = 1'b1; sw = 16'o123456;
    clr_mon();

    tv[0] = '{32'h0000_0000, 32'h8003FF78, 16'hA72E, 32'h0003FF78, 32'h0000A72E, 16'h0000, 2'd0};
    tv[1] = '{32'h0000_5A5A, 32'h800BFF78, 16'hA72E, 32'h000BFF78, 32'h00005A5A, 16'h5A5A, 2'd2};
    tv[2] = '{32'h0000_AB00, 32'h800FFF79, 16'hA72E, 32'h000FFF79, 32'h0000AB00, 16'hAB5A, 2'd3};
    tv[3] = '{32'h0000_00CD, 32'h800FFF78, 16'hA72E, 32'h000FFF78, 32'h000000CD, 16'hABCD, 2'd3};
    tv[4] = '{32'h0000_FFFF, 32'h8007FF78, 16'h1234, 32'h0007FF78, 32'h00001234, 16'hABCD, 2'd1};

    repeat (3) step();
    RESET = 1'b0;
    step();
    chk("reset_bus", 32'(bus_active()), 32'd0);
    rd(2'd0, v); chk("reset_ident", v, 32'h444D1001);
    rd(2'd1, v); chk("reset_r1", v, 32'h0);
    rd(2'd2, v); chk("reset_r2", v, 32'h0);
    rd(2'd3, v); chk("reset_r3", v, 32'hDEADBEEF);

    for (int i = 0; i < 5; i++) begin
      sw = tv[i].sw;
      arm_wr(2'd2, tv[i].r2w);
      clr_mon();
      arm_wr(2'd1, tv[i].r1w);
      chk($sformatf("v%0d_npr_next", i), 32'(npr_out_h), 32'd1);
      wait_idle(100, ok);
      chk($sformatf("v%0d_done", i), 32'(ok), 32'd1);
      rd(2'd1, v); chk($sformatf("v%0d_r1", i), v, tv[i].exp_r1);
      rd(2'd2, v); chk($sformatf("v%0d_r2", i), v, tv[i].exp_r2);
      chk($sformatf("v%0d_lights", i), 32'(lights), 32'(tv[i].exp_lights));
      chk($sformatf("v%0d_c_msyn", i), 32'(c_msyn), 32'(tv[i].exp_c));
      chk($sformatf("v%0d_deskew", i), 32'(first_msyn - first_bbsy), 32'd15);
      chk($sformatf("v%0d_order", i),
          32'(first_npr >= 0 && first_npr < first_sack && first_sack < first_bbsy && first_bbsy < first_msyn),
          32'd1);
      chk($sformatf("v%0d_msyn_len", i), 32'(msyn_cnt), 32'd1);
      chk($sformatf("v%0d_bus_idle", i), 32'(bus_active()), 32'd0);
    end

    grant_en = 1'b0;
    clr_mon();
    arm_wr(2'd1, 32'h8003FF78);
    repeat (995) step();
    rd(2'd1, v); chk("ng_busy_995", 32'(v[31]), 32'd1);
    chk("ng_npr_995", 32'(npr_out_h), 32'd1);
    wait_idle(20, ok);
    chk("ng_done", 32'(ok), 32'd1);
    rd(2'd1, v); chk("ng_r1", v, 32'h4003FF78);
    chk("ng_bus_idle", 32'(bus_active()), 32'd0);
    chk("ng_no_msyn", 32'(msyn_cnt + (first_sack >= 0 ? 1 : 0)), 32'd0);
    grant_en = 1'b1;

    arm_wr(2'd2, 32'h0000_7777);
    clr_mon();
    arm_wr(2'd1, 32'h8003E000);
    wait_idle(1100, ok);
    chk("ns_done", 32'(ok), 32'd1);
    rd(2'd1, v); chk("ns_r1", v, 32'h2003E000);
    rd(2'd2, v); chk("ns_r2", v, 32'h00007777);
    chk("ns_msyn_len", 32'(msyn_cnt), 32'd1000);
    chk("ns_bus_idle", 32'(bus_active()), 32'd0);

    clr_mon();
    arm_wr(2'd1, 32'h8003FF78);
    repeat (4) step();
    chk("in_bbsy", 32'(bbsy_out_h), 32'd1);
    chk("in_msyn_pre", 32'(msyn_out_h), 32'd0);
    chk("in_addr", 32'(a_out_h), 32'h3FF78);
    arm_wr(2'd1, 32'h800FFF79);
    rd(2'd1, v); chk("in_restart_ignored", v, 32'h8003FF78);
    init_in_h = 1'b1;
    #1;
    chk("in_same_cycle", 32'(bus_active()), 32'd0);
    step();
    init_in_h = 1'b0;
    rd(2'd1, v); chk("in_r1", v, 32'h1003FF78);
    step();
    chk("in_bus_idle", 32'(bus_active()), 32'd0);
    chk("in_no_msyn", 32'(msyn_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
